mc_apb_regbank: RTL and testbench

Parametrised APB configuration register bank for the memory controller, replacing the single-channel fixed map with NUM_CH independent timing and refresh register sets. Software writes go to shadow registers; a per-channel commit request copies shadow to active outputs only when that channel's array sequencer reports idle, so timing never changes mid-command. Sits between the APB interconnect and the per-channel array sequencers and refresh timers.

---
 rtl/mc_apb_regbank.sv | 206 ++++++++++++++++++++
 tb/tb_mc_apb_regbank.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_apb_regbank.sv
// APB register bank: per-channel shadow timing/refresh sets, committed to active outputs when the channel is idle.
// Optional MC_APB_SLVERR_EN: drive apb_pslverr for unmapped accesses and writes to STATUS.
module mc_apb_regbank #(
    parameter int NUM_CH     = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    apb_pclk,
    input  logic                    apb_prst,
    input  logic                    apb_psel,
    input  logic                    apb_penable,
    input  logic                    apb_pwrite,
    input  logic [ADDR_WIDTH-1:0]   apb_paddr,
    input  logic [DATA_WIDTH-1:0]   apb_pwdata,
    output logic                    apb_pready,
    output logic [DATA_WIDTH-1:0]   apb_prdata,
    output logic                    apb_pslverr,
    input  logic [NUM_CH-1:0]       ch_idle,
    output logic                    mc_en,
    output logic [1:0]              axi2array_rw_prio,
    output logic [8*NUM_CH-1:0]     array_tRAS,
    output logic [8*NUM_CH-1:0]     array_tRP,
    output logic [8*NUM_CH-1:0]     array_tRC,
    output logic [8*NUM_CH-1:0]     array_tRCD_WR,
    output logic [8*NUM_CH-1:0]     array_tRCD_RD,
    output logic [8*NUM_CH-1:0]     array_tWR,
    output logic [8*NUM_CH-1:0]     array_tRTP,
    output logic [25*NUM_CH-1:0]    array_rf_period_0,
    output logic [25*NUM_CH-1:0]    array_rf_period_1,
    output logic [NUM_CH-1:0]       array_rf_period_sel,
    output logic [NUM_CH-1:0]       array_cfg_upd
);

    // Per-channel commit FSM
    //   state  | meaning
    //   S_IDLE | no commit outstanding, active set is current
    //   S_PEND | commit requested, waiting for ch_idle to load active <- shadow
    typedef enum logic {S_IDLE, S_PEND} ch_state_t;

    typedef struct packed {
        logic [7:0]  trtp, twr, trcd_rd, trcd_wr, trc, trp, tras;
        logic [24:0] rf0, rf1;
        logic        sel;
    } ch_cfg_t;

    localparam ch_cfg_t CFG_RST = '{trtp: 8'h03, twr: 8'h06, trcd_rd: 8'h07, trcd_wr: 8'h07,
                                    trc: 8'h16, trp: 8'h06, tras: 8'h10,
                                    rf0: 25'd500, rf1: 25'd520, sel: 1'b0};

    localparam logic [ADDR_WIDTH-1:0] A_CTRL   = 'h00;
    localparam logic [ADDR_WIDTH-1:0] A_COMMIT = 'h04;
    localparam logic [ADDR_WIDTH-1:0] A_STATUS = 'h08;
    localparam logic [ADDR_WIDTH-1:0] A_CH     = 'h40;

    ch_state_t             state  [NUM_CH];
    ch_cfg_t               shadow [NUM_CH];
    ch_cfg_t               active [NUM_CH];
    logic [15:0]           commit_cnt;
    logic [NUM_CH-1:0]     pend;
    logic [NUM_CH-1:0]     apply;
    logic [NUM_CH-1:0]     commit_set;
    logic [ADDR_WIDTH-1:0] ch_rel;
    logic [31:0]           ch_num;
    logic [4:0]            ch_off;
    logic                  is_ch;
    logic                  is_status;
    logic                  hit;
    logic                  access;
    logic                  wr_done;
    logic [DATA_WIDTH-1:0] rd_data;

    assign access     = apb_psel & apb_penable;
    assign ch_rel     = apb_paddr - A_CH;
    assign ch_num     = 32'(ch_rel >> 5);
    assign ch_off     = ch_rel[4:0];
    assign is_ch      = (apb_paddr >= A_CH);
    assign is_status  = (apb_paddr == A_STATUS);
    assign wr_done    = access & apb_pready & apb_pwrite & hit & ~is_status;
    assign commit_set = (wr_done && apb_paddr == A_COMMIT) ? apb_pwdata[NUM_CH-1:0] : '0;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign pend[c]                         = (state[c] == S_PEND);
        assign apply[c]                        = pend[c] & ch_idle[c];
        assign array_tRAS[8*c +: 8]            = active[c].tras;
        assign array_tRP[8*c +: 8]             = active[c].trp;
        assign array_tRC[8*c +: 8]             = active[c].trc;
        assign array_tRCD_WR[8*c +: 8]         = active[c].trcd_wr;
        assign array_tRCD_RD[8*c +: 8]         = active[c].trcd_rd;
        assign array_tWR[8*c +: 8]             = active[c].twr;
        assign array_tRTP[8*c +: 8]            = active[c].trtp;
        assign array_rf_period_0[25*c +: 25]   = active[c].rf0;
        assign array_rf_period_1[25*c +: 25]   = active[c].rf1;
        assign array_rf_period_sel[c]          = active[c].sel;
    end

    always_comb begin
        hit     = 1'b0;
        rd_data = '0;
        if (!is_ch) begin
            if (apb_paddr == A_CTRL) begin
                hit     = 1'b1;
                rd_data = {29'd0, axi2array_rw_prio, mc_en};
            end else if (apb_paddr == A_COMMIT) begin
                hit     = 1'b1;
                rd_data = 32'(pend);
            end else if (is_status) begin
                hit     = 1'b1;
                rd_data = {16'd0, commit_cnt};
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (ch_num == 32'(c)) begin
                    hit = 1'b1;
                    case (ch_off)
                        5'h00:   rd_data = {8'd0, shadow[c].trc, shadow[c].trp, shadow[c].tras};
                        5'h04:   rd_data = {shadow[c].trtp, shadow[c].twr, shadow[c].trcd_rd, shadow[c].trcd_wr};
                        5'h08:   rd_data = {7'd0, shadow[c].rf0};
                        5'h0C:   rd_data = {7'd0, shadow[c].rf1};
                        5'h10:   rd_data = {31'd0, shadow[c].sel};
                        default: hit = 1'b0;
                    endcase
                end
            end
        end
    end

`ifdef MC_APB_SLVERR_EN
    logic slverr_q;
    assign apb_pslverr = slverr_q;
`else
    assign apb_pslverr = 1'b0;
`endif

    always_ff @(posedge apb_pclk) begin
        if (apb_prst) begin
            apb_pready        <= 1'b0;
            apb_prdata        <= '0;
`ifdef MC_APB_SLVERR_EN
            slverr_q          <= 1'b0;
`endif
            mc_en             <= 1'b0;
            axi2array_rw_prio <= 2'd0;
            commit_cnt        <= 16'd0;
            array_cfg_upd     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                state[c]  <= S_IDLE;
                shadow[c] <= CFG_RST;
                active[c] <= CFG_RST;
            end
        end else begin
            // One wait state: data/error captured in the first access cycle, pready the next.
            apb_pready <= access & ~apb_pready;
            if (access && !apb_pready) begin
                apb_prdata <= apb_pwrite ? '0 : rd_data;
`ifdef MC_APB_SLVERR_EN
                slverr_q   <= ~hit | (apb_pwrite & is_status);
`endif
            end

            array_cfg_upd <= apply;
            if (|apply)
                commit_cnt <= commit_cnt + 16'd1;

            // A commit set on the apply edge keeps the channel pending.
            for (int c = 0; c < NUM_CH; c++) begin
                case (state[c])
                    S_IDLE: if (commit_set[c]) state[c] <= S_PEND;
                    S_PEND: if (ch_idle[c]) begin
                        active[c] <= shadow[c];
                        if (!commit_set[c]) state[c] <= S_IDLE;
                    end
                    default: state[c] <= S_IDLE;
                endcase
            end

            if (wr_done) begin
                if (apb_paddr == A_CTRL) begin
                    mc_en             <= apb_pwdata[0];
                    axi2array_rw_prio <= apb_pwdata[2:1];
                end
                for (int c = 0; c < NUM_CH; c++) begin
                    if (is_ch && ch_num == 32'(c)) begin
                        case (ch_off)
                            5'h00: begin
                                shadow[c].tras <= apb_pwdata[7:0];
                                shadow[c].trp  <= apb_pwdata[15:8];
                                shadow[c].trc  <= apb_pwdata[23:16];
                            end
                            5'h04: begin
                                shadow[c].trcd_wr <= apb_pwdata[7:0];
                                shadow[c].trcd_rd <= apb_pwdata[15:8];
                                shadow[c].twr     <= apb_pwdata[23:16];
                                shadow[c].trtp    <= apb_pwdata[31:24];
                            end
                            5'h08:   shadow[c].rf0 <= apb_pwdata[24:0];
                            5'h0C:   shadow[c].rf1 <= apb_pwdata[24:0];
                            5'h10:   shadow[c].sel <= apb_pwdata[0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mc_apb_regbank.sv
// Randomized bench for mc_apb_regbank with a word-level reference model and directed literal checks.
`timescale 1ns/1ps
module tb_mc_apb_regbank;
    localparam int NUM_CH = 2;
    localparam int AW     = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [AW-1:0]        paddr = '0;
    logic [31:0]          pwdata = '0;
    logic [NUM_CH-1:0]    ch_idle;
    logic                 apb_pready, apb_pslverr, mc_en;
    logic [31:0]          apb_prdata;
    logic [1:0]           rw_prio;
    logic [8*NUM_CH-1:0]  t_ras, t_rp, t_rc, t_rcd_wr, t_rcd_rd, t_wr, t_rtp;
    logic [25*NUM_CH-1:0] rf0, rf1;
    logic [NUM_CH-1:0]    rf_sel, cfg_upd;

    mc_apb_regbank #(.NUM_CH(NUM_CH), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .apb_pclk(clk), .apb_prst(rst), .apb_psel(psel), .apb_penable(penable),
        .apb_pwrite(pwrite), .apb_paddr(paddr), .apb_pwdata(pwdata),
        .apb_pready(apb_pready), .apb_prdata(apb_prdata), .apb_pslverr(apb_pslverr),
        .ch_idle(ch_idle), .mc_en(mc_en), .axi2array_rw_prio(rw_prio),
        .array_tRAS(t_ras), .array_tRP(t_rp), .array_tRC(t_rc),
        .array_tRCD_WR(t_rcd_wr), .array_tRCD_RD(t_rcd_rd), .array_tWR(t_wr), .array_tRTP(t_rtp),
        .array_rf_period_0(rf0), .array_rf_period_1(rf1),
        .array_rf_period_sel(rf_sel), .array_cfg_upd(cfg_upd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

`ifdef MC_APB_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    // Reference model: registers kept as 32-bit words, five per channel.
    logic [31:0] m_sh  [NUM_CH][5];
    logic [31:0] m_act [NUM_CH][5];
    logic [NUM_CH-1:0] m_pend, m_upd;
    logic [15:0] m_cnt;
    logic        m_en, m_ready, m_err;
    logic [1:0]  m_prio;
    logic [31:0] m_prdata;
    bit          m_valid = 1'b0;
    int          poke_req = 0;
    int          poke_seen = 0;

    function automatic logic [31:0] rst_word(input int r);
        case (r)
            0: return 32'h0016_0610;
            1: return 32'h0306_0707;
            2: return 32'd500;
            3: return 32'd520;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] reg_mask(input int r);
        case (r)
            0: return 32'h00FF_FFFF;
            1: return 32'hFFFF_FFFF;
            2, 3: return 32'h01FF_FFFF;
            default: return 32'h0000_0001;
        endcase
    endfunction

    // 0 unmapped, 1 CTRL, 2 COMMIT, 3 STATUS, 4 channel register
    function automatic int m_decode(input logic [AW-1:0] a, output int ch, output int r);
        int ia;
        ia = int'(a);
        ch = 0;
        r  = 0;
        if (ia % 4 != 0) return 0;
        if (ia == 0) return 1;
        if (ia == 4) return 2;
        if (ia == 8) return 3;
        if (ia < 'h40) return 0;
        ch = (ia - 'h40) / 32;
        r  = ((ia - 'h40) % 32) / 4;
        if (ch < NUM_CH && r <= 4) return 4;
        return 0;
    endfunction

    always @(posedge clk) begin : model
        int ch, r, kind;
        logic [NUM_CH-1:0] apply, setb;
        bit done_wr;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++)
                for (int k = 0; k < 5; k++) begin
                    m_sh[c][k]  = rst_word(k);
                    m_act[c][k] = rst_word(k);
                end
            m_pend = '0; m_upd = '0; m_cnt = 16'd0; m_en = 1'b0; m_prio = 2'd0;
            m_ready = 1'b0; m_err = 1'b0; m_prdata = 32'd0;
            m_valid = 1'b1;
        end else begin
            if (poke_seen != poke_req) begin
                m_cnt = 16'hFFFF;
                poke_seen = poke_req;
            end
            kind = m_decode(paddr, ch, r);
            if (psel && penable && !m_ready) begin
                m_err = SLV && ((kind == 0) || (pwrite && kind == 3));
                if (pwrite) m_prdata = 32'd0;
                else case (kind)
                    1: m_prdata = {29'd0, m_prio, m_en};
                    2: m_prdata = 32'(m_pend);
                    3: m_prdata = {16'd0, m_cnt};
                    4: m_prdata = m_sh[ch][r];
                    default: m_prdata = 32'd0;
                endcase
            end
            done_wr = psel && penable && m_ready && pwrite;
            setb    = (done_wr && kind == 2) ? pwdata[NUM_CH-1:0] : '0;
            apply   = m_pend & ch_idle;
            for (int c = 0; c < NUM_CH; c++)
                if (apply[c])
                    for (int k = 0; k < 5; k++) m_act[c][k] = m_sh[c][k];
            m_upd = apply;
            if (apply != '0) m_cnt = m_cnt + 16'd1;
            m_pend = setb | (m_pend & ~ch_idle);
            if (done_wr) begin
                if (kind == 1) begin
                    m_en   = pwdata[0];
                    m_prio = pwdata[2:1];
                end else if (kind == 4) begin
                    m_sh[ch][r] = pwdata & reg_mask(r);
                end
            end
            m_ready = psel && penable && !m_ready;
        end
    end

    always @(negedge clk) begin : compare
        logic [8*NUM_CH-1:0]  e_ras, e_rp, e_rc, e_cwr, e_crd, e_wr, e_rtp;
        logic [25*NUM_CH-1:0] e_rf0, e_rf1;
        logic [NUM_CH-1:0]    e_sel;
        if (m_valid) begin
            for (int c = 0; c < NUM_CH; c++) begin
                e_ras[8*c +: 8]  = m_act[c][0][7:0];
                e_rp[8*c +: 8]   = m_act[c][0][15:8];
                e_rc[8*c +: 8]   = m_act[c][0][23:16];
                e_cwr[8*c +: 8]  = m_act[c][1][7:0];
                e_crd[8*c +: 8]  = m_act[c][1][15:8];
                e_wr[8*c +: 8]   = m_act[c][1][23:16];
                e_rtp[8*c +: 8]  = m_act[c][1][31:24];
                e_rf0[25*c +: 25] = m_act[c][2][24:0];
                e_rf1[25*c +: 25] = m_act[c][3][24:0];
                e_sel[c]         = m_act[c][4][0];
            end
            chk("pready", 64'(apb_pready), 64'(m_ready));
            if (m_ready) begin
                chk("prdata", 64'(apb_prdata), 64'(m_prdata));
                chk("pslverr", 64'(apb_pslverr), 64'(m_err));
            end
            chk("mc_en", 64'(mc_en), 64'(m_en));
            chk("rw_prio", 64'(rw_prio), 64'(m_prio));
            chk("cfg_upd", 64'(cfg_upd), 64'(m_upd));
            chk("tRAS", 64'(t_ras), 64'(e_ras));
            chk("tRP", 64'(t_rp), 64'(e_rp));
            chk("tRC", 64'(t_rc), 64'(e_rc));
            chk("tRCD_WR", 64'(t_rcd_wr), 64'(e_cwr));
            chk("tRCD_RD", 64'(t_rcd_rd), 64'(e_crd));
            chk("tWR", 64'(t_wr), 64'(e_wr));
            chk("tRTP", 64'(t_rtp), 64'(e_rtp));
            chk("rf_period_0", 64'(rf0), 64'(e_rf0));
            chk("rf_period_1", 64'(rf1), 64'(e_rf1));
            chk("rf_sel", 64'(rf_sel), 64'(e_sel));
        end
    end

    int upd0_seen = 0;
    always @(negedge clk) if (cfg_upd[0] === 1'b1) upd0_seen++;

    bit                rand_idle = 1'b0;
    logic [NUM_CH-1:0] idle_val  = '0;
    initial begin
        ch_idle = '0;
        forever begin
            @(posedge clk); #1;
            ch_idle = rand_idle ? NUM_CH'($urandom) : idle_val;
        end
    end

    task automatic apb_xfer(input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                            output logic [31:0] rd, output logic err,
                            input bit set_idle = 1'b0, input logic [NUM_CH-1:0] iv = '0);
        int n;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d;
        @(posedge clk); #1;
        penable = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1 && set_idle) idle_val = iv;
        end while (apb_pready !== 1'b1 && n < 6);
        chk("wait_state", 64'(n), 64'd2);
        rd  = apb_prdata;
        err = apb_pslverr;
        @(posedge clk); #1;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
        logic [31:0] rd; logic e;
        apb_xfer(1'b1, a, d, rd, e);
    endtask

    task automatic rd_chk(input string nm, input logic [AW-1:0] a, input logic [31:0] exp);
        logic [31:0] rd; logic e;
        apb_xfer(1'b0, a, 32'd0, rd, e);
        chk(nm, 64'(rd), 64'(exp));
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          u0;
        logic [AW-1:0] addr_tab [14];
        addr_tab = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h30, 8'h40, 8'h44, 8'h48,
                     8'h4C, 8'h50, 8'h54, 8'h64, 8'h70, 8'h80};

        cycles(3);
        rst = 1'b0;
        cycles(1);

        chk("rst_prdata", 64'(apb_prdata), 64'd0);
        chk("rst_tRAS", 64'(t_ras), 64'h1010);
        rd_chk("rd_ch0_rf0", 8'h48, 32'd500);
        rd_chk("rd_ch1_rf1", 8'h6C, 32'd520);
        rd_chk("rd_status0", 8'h08, 32'd0);

        idle_val = 2'b00;
        wr(8'h40, 32'h0020_1108);
        rd_chk("rd_ch0_t0", 8'h40, 32'h0020_1108);
        chk("tRAS_held", 64'(t_ras[7:0]), 64'h10);
        wr(8'h04, 32'h1);
        cycles(3);
        u0 = upd0_seen;
        idle_val = 2'b01;
        cycles(4);
        idle_val = 2'b00;
        chk("tRAS_new", 64'(t_ras[7:0]), 64'h08);
        chk("tRP_new", 64'(t_rp[7:0]), 64'h11);
        chk("tRC_new", 64'(t_rc[7:0]), 64'h20);
        chk("upd0_pulses", 64'(upd0_seen - u0), 64'd1);
        rd_chk("rd_status1", 8'h08, 32'd1);

        idle_val = 2'b10;
        wr(8'h04, 32'h3);
        cycles(2);
        rd_chk("rd_pend_ch0", 8'h04, 32'h1);
        rd_chk("rd_status2", 8'h08, 32'd2);
        idle_val = 2'b11;
        cycles(3);
        idle_val = 2'b00;
        rd_chk("rd_pend_none", 8'h04, 32'h0);
        rd_chk("rd_status3", 8'h08, 32'd3);

        wr(8'h04, 32'h2);
        apb_xfer(1'b1, 8'h64, 32'h0A0B_0C0D, rd, e, 1'b1, 2'b10);
        idle_val = 2'b00;
        cycles(2);
        chk("same_edge_tRCD_WR", 64'(t_rcd_wr[15:8]), 64'h07);
        chk("same_edge_tRTP", 64'(t_rtp[15:8]), 64'h03);
        rd_chk("same_edge_pend", 8'h04, 32'h0);
        rd_chk("same_edge_shadow", 8'h64, 32'h0A0B_0C0D);

        @(negedge clk);
        dut.commit_cnt = 16'hFFFF;
        poke_req++;
        idle_val = 2'b01;
        wr(8'h04, 32'h1);
        cycles(3);
        idle_val = 2'b00;
        rd_chk("status_wrap", 8'h08, 32'h0);

        wr(8'h00, 32'h5);
        chk("ctrl_en", 64'(mc_en), 64'd1);
        chk("ctrl_prio", 64'(rw_prio), 64'd2);

        apb_xfer(1'b0, 8'h30, 32'd0, rd, e);
        chk("unmapped_rd_data", 64'(rd), 64'd0);
        chk("unmapped_rd_err", 64'(e), 64'(SLV));
        apb_xfer(1'b1, 8'h08, 32'h1234, rd, e);
        chk("status_wr_err", 64'(e), 64'(SLV));
        rd_chk("status_unchanged", 8'h08, 32'h0);

        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h48;
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; psel = 1'b0; penable = 1'b0;
        @(negedge clk);
        chk("midrst_pready", 64'(apb_pready), 64'd0);
        chk("midrst_mc_en", 64'(mc_en), 64'd0);
        rd_chk("midrst_t0", 8'h40, 32'h0016_0610);

        rand_idle = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [AW-1:0] a;
            logic [31:0]   d;
            a = addr_tab[$urandom_range(13, 0)];
            d = $urandom;
            if (a == 8'h04) d = d & 32'h3;
            cycles($urandom_range(2, 0));
            apb_xfer($urandom_range(1, 0) == 1, a, d, rd, e);
        end
        rand_idle = 1'b0;
        cycles(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
